alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execute-stage ALU that consumes the 3-bit ALU control code produced by the ALU decoder, together with two operands, and returns a registered result through a valid/ready handshake. Single-cycle ops complete one cycle after acceptance; shift-left-logical runs iteratively, one bit per cycle, under a small FSM. It sits between the ID/EX pipeline register and the EX/MEM register and gives the hazard unit a `busy` indication for stalls.

## Interface
- `DATA_WIDTH`, 32, operand/result width (power of two, ≥ 8)
- `CONTROL_WIDTH`, 3, width of the ALU control code
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operation presented
- `in_ready`  out  1  unit can accept an operation this cycle
- `alu_control`  in  CONTROL_WIDTH  op code: 000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt, 111 lui (pass B), 110 unused
- `src_a`  in  DATA_WIDTH  operand A
- `src_b`  in  DATA_WIDTH  operand B / shift amount / lui immediate
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer takes result
- `result`  out  DATA_WIDTH  registered result
- `zero`  out  1  registered (result == 0)
- `busy`  out  1  iterative shift in progress

## Operation
- FSM states: IDLE, SHIFT.
- `in_ready` = (state == IDLE) && (!out_valid || out_ready); combinational.
- Accept = `in_valid && in_ready`; operands and code captured at that edge.
- Arithmetic: add/sub modulo 2^DATA_WIDTH, no carry/overflow output. slt: signed compare, result 1 or 0 (zero-extended). and/or: bitwise. lui: result = `src_b`. Code 110: result = 0.
- sll: shift amount = low log2(DATA_WIDTH) bits of `src_b`; upper bits ignored. Amount 0 → completes as single-cycle op.
- sll with amount n > 0: IDLE → SHIFT; accumulator ← `src_a`, counter ← n. Each SHIFT cycle: accumulator <<= 1, counter −= 1. On the cycle counter goes 1 → 0: `result` ← shifted value, `out_valid` ← 1, state → IDLE.
- Output register: loaded on completion; holds `result`/`zero` stable while `out_valid && !out_ready`. `out_valid` clears on `out_ready` unless a new completion lands on the same edge (then it stays 1 with the new result).
- `busy` = (state == SHIFT).
- Inputs are ignored while `in_ready` = 0; no queueing.

## Timing
- Reset (`rst_n` low, async): state IDLE, `out_valid` 0, `result` 0, `zero` 1, `busy` 0, counter/accumulator 0; `in_ready` therefore 1.
- Single-cycle op accepted at edge k: `out_valid` = 1 from edge k.
- sll amount n > 0 accepted at edge k: `busy` 1 from edge k to edge k+n; `out_valid` = 1 from edge k+n.
- Back-to-back: with `out_ready` held 1, one single-cycle op is accepted every cycle (throughput 1/cycle).
- Backpressure: `out_valid && !out_ready` forces `in_ready` 0; a shift in progress completes into the held slot only after the slot drains (the SHIFT state waits at counter = 1 until `!out_valid || out_ready`).
- Reset mid-shift: operation aborted, no result produced, all outputs at reset values.

## Structure
- Package `alu_pkg`: `alu_op_e` enum (ADD=000, SUB=001, AND=010, OR=011, SLL=100, SLT=101, LUI=111), `CONTROL_WIDTH` constant; shared with the ALU decoder.
- Sub-module `alu_comb`: purely combinational single-cycle ops (add, sub, and, or, slt, lui, default 0). The top level holds the FSM, shift datapath, and output register.

## Test plan
- Add/sub wrap: add 0xFFFFFFFF + 1 → result 0, zero 1, one cycle after accept; sub 5 − 7 → 0xFFFFFFFE, zero 0.
- Signed slt: A = 0xFFFFFFFF (−1), B = 1 → result 1; A = 1, B = 0xFFFFFFFF → 0.
- Iterative sll: A = 0x00000003, B = 0x00000025 (amount 5) → `busy` high 5 cycles, result 0x00000060 at edge k+5; amount 0 → result = A after 1 cycle.
- Lui/unused: code 111, B = 0xABCDE000 → result 0xABCDE000; code 110 → result 0, zero 1.
- Backpressure: hold `out_ready` 0 for 3 cycles after a result → `result` stable, `in_ready` 0, a presented op not accepted; release → result taken, new op accepted on the same edge.
- Reset mid-shift: assert `rst_n` low at cycle 2 of an amount-10 sll → `out_valid` 0, `busy` 0, `zero` 1 immediately; after release the next add completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU control-code encoding and execute-unit FSM states.
//               Imported by the ALU decoder and the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Width of the ALU control code driven by the decoder
  localparam int CONTROL_WIDTH = 3;

  // ALU control codes; 3'b110 is unused and produces a zero result
  typedef enum logic [CONTROL_WIDTH-1:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    SLL = 3'b100,
    SLT = 3'b101,
    LUI = 3'b111
  } alu_op_e;

  // Execute-unit control states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb
// Description : Purely combinational single-cycle ALU operations
//               (add, sub, and, or, slt, lui). Unknown codes give zero.
//               Shift-left is handled iteratively by the execute unit.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb
#(
  parameter int DATA_WIDTH = 32
)
(
  input  logic [alu_pkg::CONTROL_WIDTH-1:0] i_op,
  input  logic [DATA_WIDTH-1:0]             i_a,
  input  logic [DATA_WIDTH-1:0]             i_b,
  output logic [DATA_WIDTH-1:0]             o_y
);

  import alu_pkg::*;

  logic w_lt;

  // Two's-complement signed compare for slt
  assign w_lt = ($signed(i_a) < $signed(i_b));

  // Single-cycle operation select; add/sub wrap naturally at DATA_WIDTH bits
  always_comb begin
    o_y = '0;
    case (i_op)
      ADD:     o_y = i_a + i_b;
      SUB:     o_y = i_a - i_b;
      AND:     o_y = i_a & i_b;
      OR:      o_y = i_a | i_b;
      SLT:     o_y = {{(DATA_WIDTH-1){1'b0}}, w_lt};
      LUI:     o_y = i_b;
      default: o_y = '0;
    endcase
  end

endmodule : alu_comb
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage ALU with valid/ready handshake. Single-cycle
//               ops complete one cycle after acceptance; sll shifts one bit
//               per cycle under a two-state FSM and raises busy meanwhile.
//               Result and zero flag are registered and held under
//               backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
#(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = alu_pkg::CONTROL_WIDTH
)
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CONTROL_WIDTH-1:0] alu_control,
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     zero,
  output logic                     busy
);

  import alu_pkg::*;

  // Shift amount uses only the low log2(DATA_WIDTH) bits of src_b
  localparam int C_SHIFT_W = $clog2(DATA_WIDTH);

  alu_state_e             r_state;
  logic [DATA_WIDTH-1:0]  r_acc;
  logic [C_SHIFT_W-1:0]   r_cnt;
  logic [DATA_WIDTH-1:0]  r_result;
  logic                   r_zero;
  logic                   r_out_valid;

  logic [DATA_WIDTH-1:0]  w_comb_y;
  logic [DATA_WIDTH-1:0]  w_single_y;
  logic [DATA_WIDTH-1:0]  w_acc_shl;
  logic [C_SHIFT_W-1:0]   w_amt;
  logic                   w_slot_free;
  logic                   w_accept;
  logic                   w_is_sll;
  logic                   w_start_shift;
  logic                   w_last_step;

  alu_comb #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu_comb (
    .i_op (alu_control),
    .i_a  (src_a),
    .i_b  (src_b),
    .o_y  (w_comb_y)
  );

  // The output slot can take a new result if it is empty or draining now
  assign w_slot_free   = !r_out_valid || out_ready;
  assign in_ready      = (r_state == ST_IDLE) && w_slot_free;
  assign w_accept      = in_valid && in_ready;

  assign w_amt         = src_b[C_SHIFT_W-1:0];
  assign w_is_sll      = (alu_control == SLL);
  assign w_start_shift = w_accept && w_is_sll && (w_amt != '0);

  // A zero-amount sll completes immediately with operand A unchanged
  assign w_single_y    = w_is_sll ? src_a : w_comb_y;

  assign w_acc_shl     = r_acc << 1;
  assign w_last_step   = (r_cnt == C_SHIFT_W'(1));

  assign busy          = (r_state == ST_SHIFT);
  assign result        = r_result;
  assign zero          = r_zero;
  assign out_valid     = r_out_valid;

  // Control FSM, iterative shift datapath and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      // Consumer takes the result; a completion below overrides this
      if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_start_shift) begin
              r_state <= ST_SHIFT;
              r_acc   <= src_a;
              r_cnt   <= w_amt;
            end else begin
              r_result    <= w_single_y;
              r_zero      <= (w_single_y == '0);
              r_out_valid <= 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          if (!w_last_step) begin
            r_acc <= w_acc_shl;
            r_cnt <= r_cnt - C_SHIFT_W'(1);
          end else if (w_slot_free) begin
            // Final step lands straight in the output register
            r_acc       <= w_acc_shl;
            r_cnt       <= '0;
            r_result    <= w_acc_shl;
            r_zero      <= (w_acc_shl == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit. Expected results are
//               pushed to a scoreboard queue at acceptance and compared when
//               the unit hands a result over; timing is checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q_exp [$];

  alu_exec_unit #(
    .DATA_WIDTH    (32),
    .CONTROL_WIDTH (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of the ALU
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a << b[4:0];
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b111:  return b;
      default: return 32'd0;
    endcase
  endfunction

  // Present an op (called at posedge+1); returns at posedge+1 after acceptance
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int waits);
    alu_control = op;
    src_a       = a;
    src_b       = b;
    in_valid    = 1'b1;
    waits       = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check_val("issue_timeout", 32'(in_ready), 32'd1);
    else q_exp.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: compare each handed-over result against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check_val("sb_nonempty", 32'(q_exp.size() != 0), 32'd1);
      if (q_exp.size() != 0) begin
        logic [31:0] e;
        e = q_exp.pop_front();
        check_val("sb_result", result, e);
        check_val("sb_zero", 32'(zero), 32'(e == 32'd0));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int n;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    alu_control = 3'd0;
    src_a       = 32'd0;
    src_b       = 32'd0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_result",    result,         32'd0);
    check_val("rst_zero",      32'(zero),      32'd1);
    check_val("rst_busy",      32'(busy),      32'd0);
    check_val("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Add wrap: one cycle latency, zero flag set
    issue(3'b000, 32'hFFFF_FFFF, 32'd1, w);
    @(negedge clk);
    check_val("add_lat_valid", 32'(out_valid), 32'd1);
    check_val("add_res",       result,         32'd0);
    check_val("add_zero",      32'(zero),      32'd1);
    @(posedge clk); #1;

    // Sub wrap and signed compares, back-to-back
    issue(3'b001, 32'd5, 32'd7, w);                 check_val("b2b_wait_sub",  w, 0);
    issue(3'b101, 32'hFFFF_FFFF, 32'd1, w);         check_val("b2b_wait_slt1", w, 0);
    issue(3'b101, 32'd1, 32'hFFFF_FFFF, w);         check_val("b2b_wait_slt2", w, 0);
    issue(3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, w); check_val("b2b_wait_and",  w, 0);
    issue(3'b011, 32'hF000_0001, 32'h0000_1000, w); check_val("b2b_wait_or",   w, 0);
    issue(3'b111, 32'h1111_1111, 32'hABCD_E000, w); check_val("b2b_wait_lui",  w, 0);
    @(negedge clk);
    check_val("lui_res", result, 32'hABCD_E000);
    @(posedge clk); #1;
    issue(3'b110, 32'd5, 32'd6, w);
    @(negedge clk);
    check_val("unused_res",  result,    32'd0);
    check_val("unused_zero", 32'(zero), 32'd1);
    @(posedge clk); #1;

    // Iterative sll, amount 5 (upper bits of B ignored)
    issue(3'b100, 32'h0000_0003, 32'h0000_0025, w);
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_val("sll_busy_cycles", n, 5);
    check_val("sll_done_valid",  32'(out_valid), 32'd1);
    check_val("sll_res",         result,         32'h0000_0060);
    @(posedge clk); #1;

    // sll amount 0 completes as a single-cycle op
    issue(3'b100, 32'h1234_5678, 32'hFFFF_FFE0, w);
    @(negedge clk);
    check_val("sll0_busy",  32'(busy),      32'd0);
    check_val("sll0_valid", 32'(out_valid), 32'd1);
    check_val("sll0_res",   result,         32'h1234_5678);
    @(posedge clk); #1;

    // Random mix of all codes
    for (int i = 0; i < 12; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom, $urandom, w);
    end
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: result held, new op blocked for 3 cycles
    out_ready = 1'b0;
    issue(3'b000, 32'd10, 32'd20, w);
    in_valid    = 1'b1;
    alu_control = 3'b001;
    src_a       = 32'd100;
    src_b       = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("bp_in_ready", 32'(in_ready),  32'd0);
      check_val("bp_valid",    32'(out_valid), 32'd1);
      check_val("bp_result",   result,         32'd30);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_release_ready", 32'(in_ready), 32'd1);
    q_exp.push_back(model(3'b001, 32'd100, 32'd1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_val("bp_new_valid", 32'(out_valid), 32'd1);
    check_val("bp_new_res",   result,         32'd99);
    @(posedge clk); #1;

    // Reset in the middle of an amount-10 shift
    issue(3'b100, 32'd1, 32'd10, w);
    @(posedge clk); #1;
    check_val("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    q_exp.delete();
    #1;
    check_val("mid_rst_valid",    32'(out_valid), 32'd0);
    check_val("mid_rst_busy",     32'(busy),      32'd0);
    check_val("mid_rst_zero",     32'(zero),      32'd1);
    check_val("mid_rst_result",   result,         32'd0);
    check_val("mid_rst_in_ready", 32'(in_ready),  32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(3'b000, 32'd2, 32'd3, w);
    @(negedge clk);
    check_val("post_rst_valid", 32'(out_valid), 32'd1);
    check_val("post_rst_res",   result,         32'd5);
    repeat (3) @(posedge clk);
    #1;
    check_val("sb_drain", q_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alu_exec_unit
`default_nettype wire
